// File: rtl/dec_scan_ctrl.sv
// Registered N-to-2^N one-hot decoder with a built-in scan sequencer (display/keypad select).
// Latency: 1 clock from in/en/mode to out, idx and wrap; out always matches the new idx.
// Backpressure: none; the block accepts inputs every cycle and never stalls.
//
// Ports:
//   clk   - system clock, all state updates on rising edge
//   rst_n - synchronous active-low reset
//   en    - decoder enable; 0 blanks out
//   mode  - 0 = direct decode of in, 1 = scan
//   in    - direct-mode index
//   out   - registered one-hot select (2**IN_W bits)
//   idx   - registered current index
//   wrap  - one-cycle pulse when the scan index wraps LAST -> 0
//
// Optional build macro DEC_ACTIVE_LOW_OUT_EN: out becomes active-low (selected bit 0,
// blanked = all ones). idx and wrap are unaffected.

module dec_scan_ctrl #(
    parameter int IN_W = 3,
    parameter int DIV  = 4,
    parameter int LAST = 7
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 mode,
    input  logic [IN_W-1:0]      in,
    output logic [2**IN_W-1:0]   out,
    output logic [IN_W-1:0]      idx,
    output logic                 wrap
);

    localparam int OUT_W = 2**IN_W;
    // Divider needs at least one bit even when DIV == 1.
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(DIV - 1);
    localparam logic [IN_W-1:0]  LAST_I  = IN_W'(LAST);

`ifdef DEC_ACTIVE_LOW_OUT_EN
    localparam logic [OUT_W-1:0] BLANK = '1;
`else
    localparam logic [OUT_W-1:0] BLANK = '0;
`endif

    // Elaboration-time parameter sanity check.
    if (DIV < 1 || LAST < 0 || LAST > OUT_W - 1) begin : g_bad_param
        $error("dec_scan_ctrl: illegal parameters DIV=%0d LAST=%0d OUT_W=%0d", DIV, LAST, OUT_W);
    end

    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] cnt_nxt;
    logic [IN_W-1:0]  idx_nxt;
    logic             wrap_nxt;
    logic [OUT_W-1:0] sel;

    // Next-state decode. out is derived from idx_nxt so idx and out never skew.
    always_comb begin
        idx_nxt  = idx;
        cnt_nxt  = '0;
        wrap_nxt = 1'b0;
        if (en && mode) begin
            if (div_cnt == DIV_MAX) begin
                // >= also catches an out-of-range idx carried in from direct mode.
                if (idx >= LAST_I) begin
                    idx_nxt  = '0;
                    wrap_nxt = 1'b1;
                end else begin
                    idx_nxt = idx + IN_W'(1);
                end
            end else begin
                cnt_nxt = div_cnt + DIV_W'(1);
            end
        end else if (en) begin
            idx_nxt = in;
        end
        sel = OUT_W'(1) << idx_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_cnt <= '0;
            idx     <= '0;
            wrap    <= 1'b0;
            out     <= BLANK;
        end else begin
            div_cnt <= cnt_nxt;
            idx     <= idx_nxt;
            wrap    <= wrap_nxt;
            if (en) begin
`ifdef DEC_ACTIVE_LOW_OUT_EN
                out <= ~sel;
`else
                out <= sel;
`endif
            end else begin
                out <= BLANK;
            end
        end
    end

endmodule

// File: tb/tb_dec_scan_ctrl.sv
// Bench for dec_scan_ctrl: two instances (DIV=4/LAST=7 and DIV=2/LAST=3) share stimulus.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).

module tb_dec_scan_ctrl;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       mode;
    logic [2:0] in;
    logic [7:0] out_a, out_b;
    logic [2:0] idx_a, idx_b;
    logic       wrap_a, wrap_b;

    int tests = 0;
    int fails = 0;

    dec_scan_ctrl #(.IN_W(3), .DIV(4), .LAST(7)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .in(in),
        .out(out_a), .idx(idx_a), .wrap(wrap_a)
    );

    dec_scan_ctrl #(.IN_W(3), .DIV(2), .LAST(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .in(in),
        .out(out_b), .idx(idx_b), .wrap(wrap_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: index value, clocks spent in scan since entry, last wrap, enabled.
    int divs[2]  = '{4, 2};
    int lasts[2] = '{7, 3};
    int m_idx[2];
    int m_s[2];
    bit m_wrap[2];
    bit m_on[2];

    function automatic logic [7:0] pol(input logic [7:0] v);
`ifdef DEC_ACTIVE_LOW_OUT_EN
        return ~v;
`else
        return v;
`endif
    endfunction

    function automatic logic [7:0] exp_out(input int d);
        logic [7:0] v;
        v = m_on[d] ? 8'(1 << m_idx[d]) : 8'h00;
        return pol(v);
    endfunction

    task automatic model_edge();
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                m_idx[d] = 0; m_s[d] = 0; m_wrap[d] = 0; m_on[d] = 0;
            end else if (!en) begin
                m_on[d] = 0; m_wrap[d] = 0; m_s[d] = 0;
            end else if (!mode) begin
                m_idx[d] = int'(in); m_s[d] = 0; m_wrap[d] = 0; m_on[d] = 1;
            end else begin
                m_on[d] = 1; m_wrap[d] = 0;
                m_s[d]++;
                if (m_s[d] % divs[d] == 0) begin
                    if (m_idx[d] > lasts[d]) begin
                        m_idx[d]  = 0;
                        m_wrap[d] = 1;
                    end else begin
                        m_idx[d]  = (m_idx[d] + 1) % (lasts[d] + 1);
                        m_wrap[d] = (m_idx[d] == 0);
                    end
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: model follows the edge, outputs are sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("out_a",  32'(out_a),  32'(exp_out(0)));
        chk("idx_a",  32'(idx_a),  32'(m_idx[0]));
        chk("wrap_a", 32'(wrap_a), 32'(m_wrap[0]));
        chk("out_b",  32'(out_b),  32'(exp_out(1)));
        chk("idx_b",  32'(idx_b),  32'(m_idx[1]));
        chk("wrap_b", 32'(wrap_b), 32'(m_wrap[1]));
    endtask

    initial begin
        int wraps;
        int first_wrap;
        rst_n = 1'b0; en = 1'b1; mode = 1'b1; in = 3'd0;
        for (int d = 0; d < 2; d++) begin
            m_idx[d] = 0; m_s[d] = 0; m_wrap[d] = 0; m_on[d] = 0;
        end

        // Reset held 2 clocks with scan requested.
        step(); step();
        chk("rst_out", 32'(out_a), 32'(pol(8'h00)));
        chk("rst_idx", 32'(idx_a), 32'd0);

        // Release: first scan step after DIV=4 clocks.
        rst_n = 1'b1;
        step(); step(); step();
        chk("pre_step_idx", 32'(idx_a), 32'd0);
        step();
        chk("first_step_idx", 32'(idx_a), 32'd1);

        // Direct sweep.
        mode = 1'b0;
        for (int i = 0; i < 8; i++) begin
            in = 3'(i);
            step();
            if (i == 5) chk("direct_in5", 32'(out_a), 32'(pol(8'b0010_0000)));
        end

        // Enable drop in direct mode.
        in = 3'd3; step();
        en = 1'b0; step();
        chk("en_drop_out", 32'(out_a), 32'(pol(8'h00)));
        chk("en_drop_idx", 32'(idx_a), 32'd3);
        en = 1'b1; step();
        chk("en_back_out", 32'(out_a), 32'(pol(8'h08)));

        // Full scan from idx 0 for 64 clocks.
        rst_n = 1'b0; step();
        rst_n = 1'b1; mode = 1'b1;
        wraps = 0; first_wrap = -1;
        for (int c = 1; c <= 64; c++) begin
            step();
            if (wrap_a) begin
                wraps++;
                if (first_wrap < 0) first_wrap = c;
            end
            if (c == 31) chk("scan_c31_out", 32'(out_a), 32'(pol(8'h80)));
            if (c == 32) chk("scan_c32_out", 32'(out_a), 32'(pol(8'h01)));
        end
        chk("first_wrap_clk", 32'(first_wrap), 32'd32);
        chk("wrap_count", 32'(wraps), 32'd2);

        // Out-of-range entry into scan (instance b: DIV=2, LAST=3).
        mode = 1'b0; in = 3'd6; step();
        mode = 1'b1; step();
        chk("oor_hold", 32'(idx_b), 32'd6);
        step();
        chk("oor_idx", 32'(idx_b), 32'd0);
        chk("oor_wrap", 32'(wrap_b), 32'd1);
        chk("oor_out", 32'(out_b), 32'(pol(8'h01)));
        for (int c = 0; c < 8; c++) step();
        chk("oor_seq_end", 32'(idx_b), 32'd0);

        // Reset mid-scan at idx=5, div_cnt=2 on instance a.
        rst_n = 1'b0; step();
        rst_n = 1'b1;
        for (int c = 0; c < 22; c++) step();
        chk("mid_idx5", 32'(idx_a), 32'd5);
        rst_n = 1'b0; step();
        chk("mid_rst_out", 32'(out_a), 32'(pol(8'h00)));
        chk("mid_rst_idx", 32'(idx_a), 32'd0);
        rst_n = 1'b1;
        step(); step(); step();
        chk("mid_pre_idx", 32'(idx_a), 32'd0);
        step();
        chk("mid_idx1", 32'(idx_a), 32'd1);
        chk("mid_out1", 32'(out_a), 32'(pol(8'h02)));

        // Randomized traffic against the model.
        for (int c = 0; c < 400; c++) begin
            rst_n = ($urandom_range(0, 39) != 0);
            en    = ($urandom_range(0, 7) != 0);
            mode  = ($urandom_range(0, 3) != 0);
            in    = 3'($urandom_range(0, 7));
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
